pc_redirect: RTL and testbench

IF-stage PC register and next-PC selector, directly downstream of the ID-stage branch judge. Consumes BranchD/branch_taken plus the ID-computed targets and drives the instruction-fetch address. Holds any redirect that arrives while fetch cannot advance, so a branch or jump is never lost under stall. The MIPS delay slot is already in flight when ID resolves, so a redirect replaces the next sequential PC directly; no flush is issued.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/pc_redirect_next_pc_mux.sv | 33 +++
 rtl/pc_redirect.sv | 105 ++++++++++
 tb/tb_pc_redirect.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared IF-stage types and constants: reset/exception vectors and the redirect FSM states.
package cpu_pkg;
    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pcState_t;

    // One candidate next-PC source: whether it fires this cycle and where it goes.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] target;
    } redirect_t;
endpackage

// File: rtl/pc_redirect_next_pc_mux.sv
// Combinational redirect source decode: exception target and ID-stage branch/jump/jr target.
module next_pc_mux
    import cpu_pkg::*;
#(
    parameter logic [cpu_pkg::XLEN-1:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR
) (
    input  logic            StallD,
    input  logic            BranchD,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] PCBranchD,
    input  logic [XLEN-1:0] PCJumpD,
    input  logic            JrD,
    input  logic [XLEN-1:0] JrTargetD,
    input  logic            ExcTakenM,
    input  logic            ExcUseEpc,
    input  logic [XLEN-1:0] EpcM,
    output redirect_t       excReq,
    output redirect_t       rdReq
);
    always_comb begin
        excReq.valid  = ExcTakenM;
        excReq.target = ExcUseEpc ? EpcM : EXC_VECTOR;

        // ID outputs are stale while ID is stalled, so they cannot redirect.
        rdReq.valid = ~StallD & (BranchD | JrD);
        if (branch_taken)
            rdReq.target = PCBranchD;
        else if (BranchD)
            rdReq.target = PCJumpD;
        else
            rdReq.target = JrTargetD;
    end
endmodule

// File: rtl/pc_redirect.sv
// IF-stage PC register with a one-entry redirect hold for cycles where fetch cannot advance.
// Build option: define PC_ALIGN_CHECK_EN to report misaligned PCF on AdELF and block its fetch.
module pc_redirect #(
    parameter logic [cpu_pkg::XLEN-1:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter logic [cpu_pkg::XLEN-1:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     StallF,
    input  logic                     StallD,
    input  logic                     BranchD,
    input  logic                     branch_taken,
    input  logic [cpu_pkg::XLEN-1:0] PCBranchD,
    input  logic [cpu_pkg::XLEN-1:0] PCJumpD,
    input  logic                     JrD,
    input  logic [cpu_pkg::XLEN-1:0] JrTargetD,
    input  logic                     ExcTakenM,
    input  logic                     ExcUseEpc,
    input  logic [cpu_pkg::XLEN-1:0] EpcM,
    input  logic                     inst_ok,
    output logic                     inst_req,
    output logic [cpu_pkg::XLEN-1:0] PCF,
    output logic [cpu_pkg::XLEN-1:0] PCPlus4F,
    output logic                     AdELF,
    output logic                     RedirectPendF
);
    import cpu_pkg::*;

    pcState_t        state, stateNext;
    logic [XLEN-1:0] pcReg, pcNext;
    logic [XLEN-1:0] pendTgt, pendTgtNext;
    redirect_t       excReq, rdReq;
    logic            advance;

    next_pc_mux #(.EXC_VECTOR(EXC_VECTOR)) uMux (
        .StallD      (StallD),
        .BranchD     (BranchD),
        .branch_taken(branch_taken),
        .PCBranchD   (PCBranchD),
        .PCJumpD     (PCJumpD),
        .JrD         (JrD),
        .JrTargetD   (JrTargetD),
        .ExcTakenM   (ExcTakenM),
        .ExcUseEpc   (ExcUseEpc),
        .EpcM        (EpcM),
        .excReq      (excReq),
        .rdReq       (rdReq)
    );

    assign advance       = inst_ok & ~StallF;
    assign PCF           = pcReg;
    assign PCPlus4F      = pcReg + 32'd4;
    assign RedirectPendF = (state == PEND);

`ifdef PC_ALIGN_CHECK_EN
    assign AdELF    = (pcReg[1:0] != 2'b00);
    assign inst_req = ~rst & ~StallF & ~AdELF;
`else
    assign AdELF    = 1'b0;
    assign inst_req = ~rst & ~StallF;
`endif

    always_comb begin
        stateNext   = state;
        pcNext      = pcReg;
        pendTgtNext = pendTgt;
        case (state)
            RUN: begin
                if (advance) begin
                    if (excReq.valid)
                        pcNext = excReq.target;
                    else if (rdReq.valid)
                        pcNext = rdReq.target;
                    else
                        pcNext = PCPlus4F;
                end else if (excReq.valid | rdReq.valid) begin
                    pendTgtNext = excReq.valid ? excReq.target : rdReq.target;
                    stateNext   = PEND;
                end
            end
            PEND: begin
                // ID re-presents the same redirect while held, so only an exception can replace the latch.
                if (advance) begin
                    pcNext    = excReq.valid ? excReq.target : pendTgt;
                    stateNext = RUN;
                end else if (excReq.valid) begin
                    pendTgtNext = excReq.target;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            pcReg   <= RESET_PC;
            pendTgt <= '0;
        end else begin
            state   <= stateNext;
            pcReg   <= pcNext;
            pendTgt <= pendTgtNext;
        end
    end
endmodule

// File: tb/tb_pc_redirect.sv
// Self-checking bench for pc_redirect: directed scenarios plus randomized traffic against a queue-based PC model.
module tb_pc_redirect;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst, StallF, StallD, BranchD, branch_taken, JrD;
    logic        ExcTakenM, ExcUseEpc, inst_ok;
    logic [31:0] PCBranchD, PCJumpD, JrTargetD, EpcM;
    logic        inst_req, AdELF, RedirectPendF;
    logic [31:0] PCF, PCPlus4F;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural PC plus a queue holding at most one deferred target.
    logic [31:0] mPc;
    logic [31:0] mPend[$];

    pc_redirect dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .BranchD(BranchD),
        .branch_taken(branch_taken), .PCBranchD(PCBranchD), .PCJumpD(PCJumpD),
        .JrD(JrD), .JrTargetD(JrTargetD), .ExcTakenM(ExcTakenM), .ExcUseEpc(ExcUseEpc),
        .EpcM(EpcM), .inst_ok(inst_ok), .inst_req(inst_req), .PCF(PCF),
        .PCPlus4F(PCPlus4F), .AdELF(AdELF), .RedirectPendF(RedirectPendF)
    );

    always #5 clk = ~clk;

    function automatic logic expAdel(input logic [31:0] pc);
`ifdef PC_ALIGN_CHECK_EN
        return pc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic expReq(input logic [31:0] pc, input logic r, input logic sf);
        return !r && !sf && !expAdel(pc);
    endfunction

    task automatic clearIn();
        rst = 0; StallF = 0; StallD = 0; BranchD = 0; branch_taken = 0; JrD = 0;
        ExcTakenM = 0; ExcUseEpc = 0; inst_ok = 1;
        PCBranchD = 0; PCJumpD = 0; JrTargetD = 0; EpcM = 0;
    endtask

    // Advance one clock, updating the model from the inputs seen at that edge.
    task automatic tick();
        logic [31:0] excT, rdT, nPc;
        logic        rdv, adv;
        excT = ExcUseEpc ? EpcM : EXC_PC;
        rdv  = !StallD && (BranchD || JrD);
        rdT  = branch_taken ? PCBranchD : (BranchD ? PCJumpD : JrTargetD);
        adv  = inst_ok && !StallF;
        nPc  = mPc;
        if (rst) begin
            nPc = RST_PC;
            mPend.delete();
        end else if (adv) begin
            if (ExcTakenM)          nPc = excT;
            else if (mPend.size())  nPc = mPend[0];
            else if (rdv)           nPc = rdT;
            else                    nPc = mPc + 32'd4;
            mPend.delete();
        end else if (ExcTakenM) begin
            mPend.delete();
            mPend.push_back(excT);
        end else if (mPend.size() == 0 && rdv) begin
            mPend.push_back(rdT);
        end
        @(posedge clk);
        #1;
        mPc = nPc;
    endtask

    task automatic test_reset();
        clearIn(); rst = 1; inst_ok = 0;
        tick(); tick();
        total++; if (PCF !== RST_PC) begin bad++; $display("FAIL reset_pc: got=%h exp=%h", PCF, RST_PC); end
        total++; if (RedirectPendF !== 1'b0) begin bad++; $display("FAIL reset_pend: got=%b exp=0", RedirectPendF); end
        total++; if (AdELF !== 1'b0) begin bad++; $display("FAIL reset_adel: got=%b exp=0", AdELF); end
        total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL reset_req: got=%b exp=0", inst_req); end
        rst = 0; #1;
        total++; if (inst_req !== 1'b1) begin bad++; $display("FAIL req_after_reset: got=%b exp=1", inst_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        clearIn();
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = RST_PC + 32'(4 * i);
            total++; if (PCF !== exp) begin bad++; $display("FAIL seq_pc%0d: got=%h exp=%h", i, PCF, exp); end
        end
    endtask

    task automatic test_branch();
        clearIn(); BranchD = 1; branch_taken = 1; PCBranchD = 32'hBFC0_0040;
        tick(); clearIn();
        total++; if (PCF !== 32'hBFC0_0040) begin bad++; $display("FAIL branch_pc: got=%h exp=BFC00040", PCF); end
        total++; if (RedirectPendF !== 1'b0) begin bad++; $display("FAIL branch_pend: got=%b exp=0", RedirectPendF); end
        total++; if (PCPlus4F !== 32'hBFC0_0044) begin bad++; $display("FAIL branch_plus4: got=%h exp=BFC00044", PCPlus4F); end
    endtask

    task automatic test_jump_stall();
        clearIn(); BranchD = 1; PCJumpD = 32'hBFC0_0100; inst_ok = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (RedirectPendF !== 1'b1) begin bad++; $display("FAIL jump_pend%0d: got=%b exp=1", i, RedirectPendF); end
            total++; if (PCF !== 32'hBFC0_0040) begin bad++; $display("FAIL jump_hold%0d: got=%h exp=BFC00040", i, PCF); end
        end
        clearIn();
        tick();
        total++; if (PCF !== 32'hBFC0_0100) begin bad++; $display("FAIL jump_pc: got=%h exp=BFC00100", PCF); end
        total++; if (RedirectPendF !== 1'b0) begin bad++; $display("FAIL jump_unpend: got=%b exp=0", RedirectPendF); end
    endtask

    task automatic test_exc_in_pend();
        clearIn(); BranchD = 1; PCJumpD = 32'hBFC0_0100; inst_ok = 0;
        tick();
        clearIn(); ExcTakenM = 1; StallF = 1; #1;
        total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL stallf_req: got=%b exp=0", inst_req); end
        tick();
        total++; if (RedirectPendF !== 1'b1) begin bad++; $display("FAIL exc_pend: got=%b exp=1", RedirectPendF); end
        total++; if (PCF !== 32'hBFC0_0100) begin bad++; $display("FAIL exc_hold: got=%h exp=BFC00100", PCF); end
        clearIn();
        tick();
        total++; if (PCF !== EXC_PC) begin bad++; $display("FAIL exc_pc: got=%h exp=%h", PCF, EXC_PC); end
    endtask

    task automatic test_jr_misaligned();
        clearIn(); JrD = 1; JrTargetD = 32'h8000_0002;
        tick(); clearIn(); #1;
        total++; if (PCF !== 32'h8000_0002) begin bad++; $display("FAIL jr_pc: got=%h exp=80000002", PCF); end
        total++; if (AdELF !== expAdel(32'h8000_0002)) begin bad++; $display("FAIL jr_adel: got=%b exp=%b", AdELF, expAdel(32'h8000_0002)); end
        total++; if (inst_req !== expReq(32'h8000_0002, 0, 0)) begin bad++; $display("FAIL jr_req: got=%b exp=%b", inst_req, expReq(32'h8000_0002, 0, 0)); end
        ExcTakenM = 1; ExcUseEpc = 1; EpcM = 32'hBFC0_0200;
        tick(); clearIn();
        total++; if (PCF !== 32'hBFC0_0200) begin bad++; $display("FAIL eret_pc: got=%h exp=BFC00200", PCF); end
        total++; if (AdELF !== 1'b0) begin bad++; $display("FAIL eret_adel: got=%b exp=0", AdELF); end
    endtask

    task automatic test_stalld();
        clearIn(); StallD = 1; BranchD = 1; branch_taken = 1; PCBranchD = 32'hBFC0_0800;
        tick(); clearIn();
        total++; if (PCF !== 32'hBFC0_0204) begin bad++; $display("FAIL stalld_pc: got=%h exp=BFC00204", PCF); end
        total++; if (RedirectPendF !== 1'b0) begin bad++; $display("FAIL stalld_pend: got=%b exp=0", RedirectPendF); end
    endtask

    task automatic test_reset_in_pend();
        clearIn(); BranchD = 1; PCJumpD = 32'hBFC0_0900; inst_ok = 0;
        tick();
        total++; if (RedirectPendF !== 1'b1) begin bad++; $display("FAIL rstpend_setup: got=%b exp=1", RedirectPendF); end
        clearIn(); rst = 1; ExcTakenM = 1;
        tick();
        total++; if (PCF !== RST_PC) begin bad++; $display("FAIL rstpend_pc: got=%h exp=%h", PCF, RST_PC); end
        total++; if (RedirectPendF !== 1'b0) begin bad++; $display("FAIL rstpend_pend: got=%b exp=0", RedirectPendF); end
        clearIn();
        tick();
        total++; if (PCF !== RST_PC + 32'd4) begin bad++; $display("FAIL rstpend_drop: got=%h exp=%h", PCF, RST_PC + 32'd4); end
    endtask

    task automatic test_wrap();
        clearIn(); ExcTakenM = 1; ExcUseEpc = 1; EpcM = 32'hFFFF_FFFC;
        tick(); clearIn();
        total++; if (PCPlus4F !== 32'h0) begin bad++; $display("FAIL wrap_plus4: got=%h exp=00000000", PCPlus4F); end
        tick();
        total++; if (PCF !== 32'h0) begin bad++; $display("FAIL wrap_pc: got=%h exp=00000000", PCF); end
    endtask

    task automatic test_random();
        logic [31:0] aligned;
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 49) == 0);
            StallF       = ($urandom_range(0, 3) == 0);
            StallD       = ($urandom_range(0, 3) == 0);
            inst_ok      = ($urandom_range(0, 2) != 0);
            BranchD      = $urandom_range(0, 1);
            branch_taken = BranchD & $urandom_range(0, 1);
            JrD          = !BranchD && ($urandom_range(0, 2) == 0);
            ExcTakenM    = ($urandom_range(0, 9) == 0);
            ExcUseEpc    = $urandom_range(0, 1);
            aligned      = {$urandom()} & 32'hFFFF_FFFC;
            PCBranchD    = aligned;
            PCJumpD      = {$urandom()} & 32'hFFFF_FFFC;
            JrTargetD    = ($urandom_range(0, 7) == 0) ? $urandom() : ({$urandom()} & 32'hFFFF_FFFC);
            EpcM         = {$urandom()} & 32'hFFFF_FFFC;
            #1;
            total++; if (inst_req !== expReq(mPc, rst, StallF)) begin bad++; $display("FAIL rnd_req[%0d]: got=%b exp=%b", n, inst_req, expReq(mPc, rst, StallF)); end
            tick();
            total++; if (PCF !== mPc) begin bad++; $display("FAIL rnd_pc[%0d]: got=%h exp=%h", n, PCF, mPc); end
            total++; if (RedirectPendF !== (mPend.size() != 0)) begin bad++; $display("FAIL rnd_pend[%0d]: got=%b exp=%b", n, RedirectPendF, mPend.size() != 0); end
            total++; if (PCPlus4F !== mPc + 32'd4) begin bad++; $display("FAIL rnd_plus4[%0d]: got=%h exp=%h", n, PCPlus4F, mPc + 32'd4); end
            total++; if (AdELF !== expAdel(mPc)) begin bad++; $display("FAIL rnd_adel[%0d]: got=%b exp=%b", n, AdELF, expAdel(mPc)); end
        end
    endtask

    initial begin
        mPc = RST_PC;
        clearIn();
        test_reset();
        test_sequential();
        test_branch();
        test_jump_stall();
        test_exc_in_pend();
        test_jr_misaligned();
        test_stalld();
        test_reset_in_pend();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
